// File: rtl/push_in_db_reg_bank.sv
// rtl/push_in_db_reg_bank.sv - synchronised, debounced push-button bank with sticky W1C press events
// Optional irq_en register and registered irq output when PUSH_IRQ_EN is defined.
module push_in_db_reg_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          DB_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR = 32'hA0010000
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  input  logic [NUM_CH-1:0] push_in,
  output logic [31:0]       prdata,
  output logic              irq
);

  localparam int              CNT_W     = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [31:0]     PARAM_VAL = {16'd0, 8'(DB_CYCLES % 256), 8'(NUM_CH)};
  localparam logic [31:0]     A_LEVEL   = BASE_ADDR;
  localparam logic [31:0]     A_EVENT   = BASE_ADDR + 32'h4;
  localparam logic [31:0]     A_IRQ_EN  = BASE_ADDR + 32'h8;
  localparam logic [31:0]     A_PARAM   = BASE_ADDR + 32'hC;

  logic [NUM_CH-1:0] s1, s2;
  logic [NUM_CH-1:0] level, level_nxt;
  logic [NUM_CH-1:0] evt, evt_nxt;
  logic [NUM_CH-1:0] rise, clr;
  logic [NUM_CH-1:0] irq_en_rd;
  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];

  assign clr = (wr_en && (paddr == A_EVENT)) ? pwdata[NUM_CH-1:0] : '0;

  // Any bounce at s2 returns the counter to zero before it can reach CNT_MAX.
  always_comb begin
    level_nxt = level;
    rise      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != level[i]) begin
        if (cnt[i] == CNT_MAX) begin
          level_nxt[i] = s2[i];
          rise[i]      = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press landing on the same edge as its W1C keeps the flag set.
  assign evt_nxt = (evt & ~clr) | rise;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      evt   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      s1    <= push_in;
      s2    <= s1;
      level <= level_nxt;
      evt   <= evt_nxt;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef PUSH_IRQ_EN
  logic [NUM_CH-1:0] irq_en;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_en && (paddr == A_IRQ_EN)) irq_en <= pwdata[NUM_CH-1:0];
      irq <= |(evt & irq_en);
    end
  end

  assign irq_en_rd = irq_en;
`else
  assign irq_en_rd = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (paddr)
        A_LEVEL:  prdata = 32'(level);
        A_EVENT:  prdata = 32'(evt);
        A_IRQ_EN: prdata = 32'(irq_en_rd);
        A_PARAM:  prdata = PARAM_VAL;
        default:  prdata = '0;
      endcase
    end
  end

  if (NUM_CH < 32) begin : g_unused
    logic unused_pwdata;
    assign unused_pwdata = ^pwdata[31:NUM_CH];
  end

endmodule
